// File: rtl/pipeline_stall_ctrl_if.sv
// Stall controller bus: stage stall requests and flush request in, stall/flush/redirect out.
// The perf counter outputs exist only when STALL_PERF_EN is defined.
interface pipeline_stall_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_err;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        input  stall, flush, new_pc, wdog_err, perf_stall_cycles, perf_flush_count
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        output stall, flush, new_pc, wdog_err, perf_stall_cycles, perf_flush_count
    );
`else
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        input  stall, flush, new_pc, wdog_err
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        output stall, flush, new_pc, wdog_err
    );
`endif
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with stall watchdog.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipeline_stall_ctrl #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
);
    typedef enum logic {RUN, PEND} state_t;

    localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_err_q, wdog_err_d;
    logic [5:0]  enc;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    // Deepest requesting stage wins; patterns are always contiguous from bit 0.
    always_comb begin
        enc = 6'b000000;
        if (bus.stallreq_mem)     enc = 6'b011111;
        else if (bus.stallreq_ex) enc = 6'b001111;
        else if (bus.stallreq_id) enc = 6'b000111;
        else if (bus.stallreq_if) enc = 6'b000011;
    end

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        stall_o   = enc;
        flush_o   = 1'b0;
        new_pc_o  = 32'h0;
        unique case (state_q)
            RUN: begin
                if (bus.flush_req && !bus.stallreq_mem) begin
                    flush_o  = 1'b1;
                    new_pc_o = bus.flush_pc;
                    stall_o  = 6'b000000;
                end else if (bus.flush_req) begin
                    state_d   = PEND;
                    pend_pc_d = bus.flush_pc;
                end
            end
            PEND: begin
                // Hold the flush until the memory transaction completes; later requests are dropped.
                if (bus.stallreq_mem) begin
                    stall_o = 6'b011111;
                end else begin
                    flush_o  = 1'b1;
                    new_pc_o = pend_pc_q;
                    stall_o  = 6'b000000;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            stall_o  = 6'b000000;
            flush_o  = 1'b0;
            new_pc_o = 32'h0;
        end
    end

    always_comb begin
        wdog_cnt_d = 16'h0;
        if (stall_o[0])
            wdog_cnt_d = (wdog_cnt_q == WDOG_LIM) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
        wdog_err_d = wdog_err_q | (wdog_cnt_d == WDOG_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pend_pc_q  <= 32'h0;
            wdog_cnt_q <= 16'h0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign bus.stall    = stall_o;
    assign bus.flush    = flush_o;
    assign bus.new_pc   = new_pc_o;
    assign bus.wdog_err = wdog_err_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
    logic [31:0] perf_flush_count_q, perf_flush_count_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_stall_cycles_d = perf_stall_cycles_q;
        perf_flush_count_d  = perf_flush_count_q;
        if (stall_o[0] && perf_stall_cycles_q != 32'hFFFF_FFFF)
            perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
        if (flush_o && perf_flush_count_q != 32'hFFFF_FFFF)
            perf_flush_count_d = perf_flush_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles_q <= 32'h0;
            perf_flush_count_q  <= 32'h0;
        end else begin
            perf_stall_cycles_q <= perf_stall_cycles_d;
            perf_flush_count_q  <= perf_flush_count_d;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_cycles_q;
    assign bus.perf_flush_count  = perf_flush_count_q;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: priority, flush sequencing, reset, watchdog, perf.
module tb_pipeline_stall_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(.WDOG_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.flush_req    = 1'b0;
        bus.flush_pc     = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.stallreq_mem = 1'b1;
        bus.flush_req    = 1'b1;
        bus.flush_pc     = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b000000) begin
            errors++; $display("FAIL reset_stall got=%b exp=%b", bus.stall, 6'b000000);
        end
        checks++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
            errors++; $display("FAIL reset_flush got flush=%b new_pc=%h exp 0/0", bus.flush, bus.new_pc);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.wdog_err !== 1'b0) begin
            errors++; $display("FAIL reset_wdog got=%b exp=0", bus.wdog_err);
        end
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_priority();
        do_reset();
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b011111) begin
            errors++; $display("FAIL prio_mem_id got=%b exp=%b", bus.stall, 6'b011111);
        end
        step();
        bus.stallreq_mem = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b000111) begin
            errors++; $display("FAIL prio_id got=%b exp=%b", bus.stall, 6'b000111);
        end
        step();
        bus.stallreq_ex = 1'b1;
        bus.stallreq_if = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b001111) begin
            errors++; $display("FAIL prio_ex got=%b exp=%b", bus.stall, 6'b001111);
        end
        step();
        bus.stallreq_ex = 1'b0;
        bus.stallreq_id = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b000011) begin
            errors++; $display("FAIL prio_if got=%b exp=%b", bus.stall, 6'b000011);
        end
        step();
        bus.stallreq_if = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b000000) begin
            errors++; $display("FAIL prio_none got=%b exp=%b", bus.stall, 6'b000000);
        end
        step();
    endtask

    task automatic test_immediate_flush();
        do_reset();
        bus.flush_req   = 1'b1;
        bus.flush_pc    = 32'hBFC0_0380;
        bus.stallreq_ex = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'hBFC0_0380 || bus.stall !== 6'b000000) begin
            errors++; $display("FAIL imm_flush got flush=%b new_pc=%h stall=%b exp 1/bfc00380/000000",
                               bus.flush, bus.new_pc, bus.stall);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
            errors++; $display("FAIL imm_flush_after got flush=%b new_pc=%h exp 0/0", bus.flush, bus.new_pc);
        end
        step();
    endtask

    task automatic test_deferred_flush();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.stallreq_mem = (c < 3);
            bus.flush_req    = (c < 2);
            bus.flush_pc     = (c == 0) ? 32'h8000_0100 : ((c == 1) ? 32'h8000_0200 : 32'h0);
            @(negedge clk);
            checks++;
            if (c < 3) begin
                if (bus.stall !== 6'b011111 || bus.flush !== 1'b0) begin
                    errors++; $display("FAIL defer_wait c=%0d got stall=%b flush=%b exp 011111/0",
                                       c, bus.stall, bus.flush);
                end
            end else begin
                if (bus.flush !== 1'b1 || bus.new_pc !== 32'h8000_0100 || bus.stall !== 6'b000000) begin
                    errors++; $display("FAIL defer_flush got flush=%b new_pc=%h stall=%b exp 1/80000100/000000",
                                       bus.flush, bus.new_pc, bus.stall);
                end
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin
            errors++; $display("FAIL defer_after got flush=%b new_pc=%h exp 0/0", bus.flush, bus.new_pc);
        end
        step();
    endtask

    task automatic test_reset_pend();
        do_reset();
        bus.stallreq_mem = 1'b1;
        bus.flush_req    = 1'b1;
        bus.flush_pc     = 32'hDEAD_BEE0;
        step();
        bus.flush_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 6'b000000 || bus.flush !== 1'b0) begin
            errors++; $display("FAIL pend_in_reset got stall=%b flush=%b exp 000000/0", bus.stall, bus.flush);
        end
        step();
        reset = 1'b0;
        bus.stallreq_mem = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.stall !== 6'b000000) begin
                errors++; $display("FAIL pend_reset c=%0d got flush=%b new_pc=%h stall=%b exp 0/0/000000",
                                   c, bus.flush, bus.new_pc, bus.stall);
            end
            step();
        end
        // A fresh MEM-free flush must be immediate, which shows the state is back in RUN.
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_4000;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0000_4000) begin
            errors++; $display("FAIL pend_reset_run got flush=%b new_pc=%h exp 1/00004000", bus.flush, bus.new_pc);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.stallreq_if = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.wdog_err !== 1'b0) begin
                errors++; $display("FAIL wdog_early c=%0d got=%b exp=0", c, bus.wdog_err);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.wdog_err !== 1'b1) begin
            errors++; $display("FAIL wdog_trip got=%b exp=1", bus.wdog_err);
        end
        step();
        bus.stallreq_if = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.wdog_err !== 1'b1 || bus.stall !== 6'b000000) begin
            errors++; $display("FAIL wdog_sticky got err=%b stall=%b exp 1/000000", bus.wdog_err, bus.stall);
        end
        step();
        // Runs of 7 stalled cycles separated by one free cycle must never trip it.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            bus.stallreq_if = 1'b1;
            repeat (7) step();
            bus.stallreq_if = 1'b0;
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.wdog_err !== 1'b0) begin
            errors++; $display("FAIL wdog_7run got=%b exp=0", bus.wdog_err);
        end
        step();
    endtask

`ifdef STALL_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.stallreq_if = 1'b1;
        repeat (5) step();
        bus.stallreq_if = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bus.flush_req = 1'b1;
            bus.flush_pc  = 32'h100 * (p + 1);
            step();
            bus.flush_req = 1'b0;
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.perf_stall_cycles !== 32'd5 || bus.perf_flush_count !== 32'd2) begin
            errors++; $display("FAIL perf_counts got stall=%0d flush=%0d exp 5/2",
                               bus.perf_stall_cycles, bus.perf_flush_count);
        end
        step();
        force dut.perf_stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.perf_stall_cycles_q;
        bus.stallreq_ex = 1'b1;
        repeat (4) step();
        bus.stallreq_ex = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.perf_stall_cycles !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL perf_sat got=%h exp=ffffffff", bus.perf_stall_cycles);
        end
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        step();
        test_reset();
        test_priority();
        test_immediate_flush();
        test_deferred_flush();
        test_reset_pend();
        test_watchdog();
`ifdef STALL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage pipeline. It collects stall requests from the IF, ID, EX and MEM stages and drives the 6-bit `stall` vector consumed by the PC register and every inter-stage register (if_id, id_exe, exe_mem, mem_wb). It also sequences exception/redirect flushes so that a flush never cuts an outstanding memory transaction. It adds a stall watchdog and optional performance counters.

## Interface
- `WDOG_CYCLES`, 1024: consecutive fully-stalled cycles that trip the watchdog; legal range 2..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stallreq_if`  in  1  IF stage requests a stall (instruction fetch wait).
- `stallreq_id`  in  1  ID stage requests a stall (load-use hazard).
- `stallreq_ex`  in  1  EX stage requests a stall (multi-cycle mul/div).
- `stallreq_mem`  in  1  MEM stage requests a stall (data memory wait).
- `flush_req`  in  1  MEM-stage exception/redirect request.
- `flush_pc`  in  32  redirect target, valid with `flush_req`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- `flush`  out  1  clears all inter-stage registers this cycle.
- `new_pc`  out  32  redirect target, valid while `flush`=1.
- `wdog_err`  out  1  sticky watchdog flag.
- `perf_stall_cycles`  out  32  present only with `STALL_PERF_EN`.
- `perf_flush_count`  out  32  present only with `STALL_PERF_EN`.

## Operation
- Stall encoding is combinational and uses deepest-stage priority:
  - `stallreq_mem` → 6'b011111
  - else `stallreq_ex` → 6'b001111
  - else `stallreq_id` → 6'b000111
  - else `stallreq_if` → 6'b000011
  - else 6'b000000
- Consumers insert a bubble at stage n when stall[n]=1 and stall[n+1]=0. The controller must therefore only emit contiguous-from-bit-0 patterns.
- FSM states:
  - RUN:
    - `flush_req`=1 and `stallreq_mem`=0: `flush`=1, `new_pc`=`flush_pc`, `stall`=0, stay in RUN.
    - `flush_req`=1 and `stallreq_mem`=1: capture `flush_pc` into `pend_pc`, go to PEND; `flush`=0, stall pattern from the encoder.
  - PEND:
    - `stall` forced to 6'b011111.
    - Further `flush_req` pulses are ignored; the first request wins.
    - When `stallreq_mem`=0: `flush`=1, `new_pc`=`pend_pc`, `stall`=0, then go to RUN on the next edge.
- While `flush`=1, stall requests from IF/ID/EX are ignored that cycle and `stall`=0.
- `new_pc` is 0 whenever `flush`=0.
- Watchdog:
  - A 16-bit counter increments each cycle `stall[0]`=1 and clears on any cycle `stall[0]`=0.
  - When the counter reaches `WDOG_CYCLES`, `wdog_err` is set and the counter holds.
  - `wdog_err` clears only on `reset`. It never alters the stall or flush outputs.

## Timing
- `stall`, `flush` and `new_pc` are same-cycle combinational functions of the inputs and registered state. Downstream registers sample them on the next rising edge.
- Flush latency:
  - 0 cycles when no MEM stall is active.
  - Otherwise exactly the first cycle `stallreq_mem` is low after the request.
- Reset values: state=RUN, `pend_pc`=0, watchdog counter=0, `wdog_err`=0, perf counters=0.
- During `reset`=1, the outputs are forced to `stall`=0, `flush`=0 and `new_pc`=0, regardless of inputs.
- Reset in PEND discards the pending flush; no flush pulse follows.
- Simultaneous `flush_req` and `stallreq_ex`/`id`/`if` in RUN with no MEM stall: the flush wins.

## Configuration
- `STALL_PERF_EN` defined:
  - `perf_stall_cycles` increments on every cycle with `stall[0]`=1.
  - `perf_flush_count` increments on every cycle with `flush`=1.
  - Both are 32-bit and saturate at 32'hFFFFFFFF.
- `STALL_PERF_EN` undefined:
  - Both perf ports and their registers are absent.
  - All other behaviour is identical.

## Test plan
- Priority: `stallreq_id`=1 and `stallreq_mem`=1 in the same cycle → `stall`=6'b011111. Dropping `stallreq_mem` alone → 6'b000111. Dropping `stallreq_id` as well → 6'b000000.
- Immediate flush: in RUN, `flush_req`=1, `flush_pc`=32'hBFC00380, `stallreq_ex`=1 → same cycle `flush`=1, `new_pc`=32'hBFC00380, `stall`=0. Next cycle `flush`=0.
- Deferred flush:
  - Setup: `stallreq_mem` held high for 3 cycles; `flush_req` pulses in cycle 0 with 32'h80000100, then again in cycle 1 with 32'h80000200.
  - Cycles 0–2: `stall`=6'b011111, `flush`=0.
  - Cycle 3: `flush`=1, `new_pc`=32'h80000100.
- Reset mid-PEND: enter PEND, assert `reset` for 1 cycle, then drop `stallreq_mem` → no flush pulse, state RUN, `new_pc`=0.
- Watchdog: `WDOG_CYCLES`=8, `stallreq_if` held high → `wdog_err` rises at cycle 8 and stays high after `stallreq_if` drops. A run of 7 stalled cycles followed by 1 free cycle never sets it.
- Perf (`STALL_PERF_EN`):
  - 5 stalled cycles plus 2 flush pulses → `perf_stall_cycles`=5, `perf_flush_count`=2.
  - Preloading the stall counter near 32'hFFFFFFFF (force) and continuing to stall → it saturates at 32'hFFFFFFFF.
